// File: rtl/tiny_mmio_resp.sv
// tiny_mmio_resp -- memory-mapped byte responder on the core data bus.
//
// Decodes a 4-byte window at BASE in data space (ramsel=1):
//   offset 0 DATA   : write pushes into the TX FIFO, read peeks the head (0 if empty)
//   offset 1 STATUS : {timer_flag, underflow, overflow, count[2:0], full, empty};
//                     reading clears bits 7:5 (a same-cycle set wins)
//   offset 2 CMP    : timer compare register (read/write)
//   offset 3 CNT    : timer counter (read, write loads)
//
// Build option: define TINY_MMIO_TIMER_EN to include the timer (CMP, CNT,
// STATUS bit 7, irq). Without it, offsets 2/3 read 0, writes there are
// ignored, and irq is tied low.
//
// Ports:
//   clk, reset          single clock, asynchronous active-high reset
//   read, write         core bus strobes
//   addr, wdata         core bus address and write data
//   ramsel              1 = data space access
//   rdata               registered read data, valid the cycle after the read strobe
//   tx_data, tx_valid   FIFO head and non-empty indication
//   tx_ready            sink acceptance
//   irq                 timer flag level
//
// Drain handshake: tx_valid is high whenever the FIFO holds data and tx_data
// is the head entry; the head is consumed on every rising edge where
// tx_valid && tx_ready. tx_valid never depends on tx_ready.
//
// DEPTH must be 2 or 4; pointers use the natural binary wrap at those sizes.

module tiny_mmio_resp #(
   parameter logic [7:0] BASE  = 8'hFC,
   parameter int         DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       read,
   input  logic       write,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   input  logic       ramsel,
   output logic [7:0] rdata,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       irq
);

   localparam int         PW       = (DEPTH == 4) ? 2 : 1;
   localparam logic [2:0] FULL_CNT = 3'(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [2:0]    count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;
   logic [7:0]    rdata_q, rdata_d;

   logic          sel, wr_en, rd_en, status_rd;
   logic [1:0]    off;
   logic          empty, full, push, pop, push_ok;
   logic [7:0]    head, status;

   // Timer-facing values; tied to zero when the timer is not built.
   logic          tflag;
   logic [7:0]    cmp_rd, cnt_rd;

   assign sel       = ramsel && (addr[7:2] == BASE[7:2]);
   assign off       = addr[1:0];
   assign wr_en     = sel && write;
   assign rd_en     = sel && read;
   assign status_rd = rd_en && (off == 2'd1);

   assign empty    = (count_q == 3'd0);
   assign full     = (count_q == FULL_CNT);
   assign head     = mem_q[rd_ptr_q];
   assign pop      = !empty && tx_ready;
   assign push     = wr_en && (off == 2'd0);
   // A push into a full FIFO still fits when the head leaves on the same edge.
   assign push_ok  = push && (!full || pop);

   assign status   = {tflag, udf_q, ovf_q, count_q, full, empty};

   assign tx_valid = !empty;
   assign tx_data  = empty ? 8'h00 : head;
   assign rdata    = rdata_q;

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q + 3'(push_ok) - 3'(pop);
      ovf_d    = ovf_q;
      udf_d    = udf_q;
      rdata_d  = rdata_q;

      if (push_ok) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      // Sticky bits: clear on STATUS read, but a set in the same cycle wins.
      if (status_rd) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
      if (push && full && !pop) begin
         ovf_d = 1'b1;
      end
      if (rd_en && (off == 2'd0) && empty) begin
         udf_d = 1'b1;
      end

      if (rd_en) begin
         case (off)
            2'd0:    rdata_d = empty ? 8'h00 : head;
            2'd1:    rdata_d = status;
            2'd2:    rdata_d = cmp_rd;
            default: rdata_d = cnt_rd;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= 3'd0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         rdata_q  <= 8'h00;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
         rdata_q  <= rdata_d;
      end
   end

`ifdef TINY_MMIO_TIMER_EN
   logic [7:0] cmp_q, cmp_d;
   logic [7:0] cnt_q, cnt_d;
   logic       tflag_q, tflag_d;
   logic       match;

   always_comb begin
      match   = (cnt_q == cmp_q);
      cmp_d   = cmp_q;
      tflag_d = tflag_q;

      if (wr_en && (off == 2'd2)) begin
         cmp_d = wdata;
      end

      // A CNT write beats both the match reload and the free-running increment.
      if (wr_en && (off == 2'd3)) begin
         cnt_d = wdata;
      end else if (match) begin
         cnt_d = 8'h00;
      end else begin
         cnt_d = cnt_q + 8'h01;
      end

      if (status_rd) begin
         tflag_d = 1'b0;
      end
      if (match) begin
         tflag_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmp_q   <= 8'hFF;
         cnt_q   <= 8'h00;
         tflag_q <= 1'b0;
      end else begin
         cmp_q   <= cmp_d;
         cnt_q   <= cnt_d;
         tflag_q <= tflag_d;
      end
   end

   assign tflag  = tflag_q;
   assign cmp_rd = cmp_q;
   assign cnt_rd = cnt_q;
   assign irq    = tflag_q;
`else
   assign tflag  = 1'b0;
   assign cmp_rd = 8'h00;
   assign cnt_rd = 8'h00;
   assign irq    = 1'b0;
`endif

endmodule

// File: tb/tb_tiny_mmio_resp.sv
// Directed bench for tiny_mmio_resp (BASE=8'hFC, DEPTH=4).
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge, half a period away from the active rising edge.

module tb_tiny_mmio_resp;

   logic       clk;
   logic       reset;
   logic       read;
   logic       write;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic       ramsel;
   logic [7:0] rdata;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       irq;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q[$];

   tiny_mmio_resp #(.BASE(8'hFC), .DEPTH(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .read     (read),
      .write    (write),
      .addr     (addr),
      .wdata    (wdata),
      .ramsel   (ramsel),
      .rdata    (rdata),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .irq      (irq)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      read     = 1'b0;
      write    = 1'b0;
      ramsel   = 1'b0;
      addr     = 8'h00;
      wdata    = 8'h00;
      tx_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // ---------------- driver tasks ----------------
   // One strobe spanning exactly one rising edge; returns on the next falling edge.
   task automatic bus_write(input logic [7:0] a, input logic [7:0] d, input logic rs);
      addr   = a;
      wdata  = d;
      ramsel = rs;
      write  = 1'b1;
      @(negedge clk);
      write  = 1'b0;
      ramsel = 1'b0;
   endtask

   task automatic bus_read(input logic [7:0] a, input logic rs, output logic [7:0] d);
      addr   = a;
      ramsel = rs;
      read   = 1'b1;
      @(negedge clk);
      read   = 1'b0;
      ramsel = 1'b0;
      d      = rdata;
   endtask

   // Model-tracked push of an accepted byte.
   task automatic push_byte(input logic [7:0] d);
      bus_write(8'hFC, d, 1'b1);
      exp_q.push_back(d);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [7:0] d;
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", rdata); end
      checks++;
      if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
      checks++;
      if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
      do_reset();
`ifdef TINY_MMIO_TIMER_EN
      bus_read(8'hFF, 1'b1, d);
      checks++;
      if (d !== 8'h00) begin errors++; $display("FAIL reset_cnt: got %h want 00", d); end
      bus_read(8'hFE, 1'b1, d);
      checks++;
      if (d !== 8'hFF) begin errors++; $display("FAIL reset_cmp: got %h want ff", d); end
`endif
      bus_read(8'hFD, 1'b1, d);
      checks++;
      if (d !== 8'h01) begin errors++; $display("FAIL reset_status: got %h want 01", d); end
   endtask

   task automatic test_push_status();
      logic [7:0] d;
      do_reset();
      addr   = 8'hFC;
      wdata  = 8'h11;
      ramsel = 1'b1;
      write  = 1'b1;
      #1;
      checks++;
      if (tx_valid !== 1'b0) begin errors++; $display("FAIL no_bypass: tx_valid got %b want 0", tx_valid); end
      @(negedge clk);
      write = 1'b0;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin
         errors++; $display("FAIL first_push: valid=%b data=%h want 1/11", tx_valid, tx_data);
      end
      bus_write(8'hFC, 8'h22, 1'b1);
      bus_read(8'hFD, 1'b1, d);
      checks++;
      if (d !== 8'h08) begin errors++; $display("FAIL status_two: got %h want 08", d); end
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin
         errors++; $display("FAIL head_two: valid=%b data=%h want 1/11", tx_valid, tx_data);
      end
      bus_read(8'hFC, 1'b1, d);
      checks++;
      if (d !== 8'h11) begin errors++; $display("FAIL data_peek: got %h want 11", d); end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (rdata !== 8'h11 || tx_data !== 8'h11) begin
         errors++; $display("FAIL rdata_hold: rdata=%h head=%h want 11/11", rdata, tx_data);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] d;
      do_reset();
      exp_q.delete();
      for (int i = 0; i < 4; i++) push_byte(8'hA1 + 8'(i));
      bus_write(8'hFC, 8'hA5, 1'b1);
      bus_read(8'hFD, 1'b1, d);
      checks++;
      if (d !== 8'h32) begin errors++; $display("FAIL ovf_status: got %h want 32", d); end
      bus_read(8'hFD, 1'b1, d);
      checks++;
      if (d !== 8'h12) begin errors++; $display("FAIL ovf_cleared: got %h want 12", d); end
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin
            errors++; $display("FAIL ovf_drain%0d: valid=%b data=%h want 1/%h", i, tx_valid, tx_data, exp_q[0]);
         end
         void'(exp_q.pop_front());
         @(negedge clk);
      end
      tx_ready = 1'b0;
      checks++;
      if (tx_valid !== 1'b0) begin errors++; $display("FAIL ovf_lost: tx_valid got %b want 0", tx_valid); end
   endtask

   task automatic test_full_push_pop();
      logic [7:0] d;
      do_reset();
      exp_q.delete();
      for (int i = 0; i < 4; i++) push_byte(8'h41 + 8'(i));
      tx_ready = 1'b1;
      bus_write(8'hFC, 8'h55, 1'b1);
      tx_ready = 1'b0;
      void'(exp_q.pop_front());
      exp_q.push_back(8'h55);
      bus_read(8'hFD, 1'b1, d);
      checks++;
      if (d !== 8'h12) begin errors++; $display("FAIL fullpp_status: got %h want 12", d); end
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin
            errors++; $display("FAIL fullpp_drain%0d: valid=%b data=%h want 1/%h", i, tx_valid, tx_data, exp_q[0]);
         end
         void'(exp_q.pop_front());
         @(negedge clk);
      end
      tx_ready = 1'b0;
      checks++;
      if (tx_valid !== 1'b0) begin errors++; $display("FAIL fullpp_empty: tx_valid got %b want 0", tx_valid); end
   endtask

   task automatic test_underflow();
      logic [7:0] d;
      do_reset();
      bus_read(8'hFD, 1'b1, d);
      bus_read(8'hFC, 1'b1, d);
      checks++;
      if (d !== 8'h00) begin errors++; $display("FAIL udf_data: got %h want 00", d); end
      bus_read(8'hFD, 1'b1, d);
      checks++;
      if (d !== 8'h41) begin errors++; $display("FAIL udf_status: got %h want 41", d); end
      bus_read(8'hFD, 1'b1, d);
      checks++;
      if (d !== 8'h01) begin errors++; $display("FAIL udf_cleared: got %h want 01", d); end
   endtask

`ifdef TINY_MMIO_TIMER_EN
   task automatic test_timer();
      logic [7:0] d;
      do_reset();
      bus_write(8'hFF, 8'h10, 1'b1);
      bus_write(8'hFE, 8'h03, 1'b1);
      bus_write(8'hFF, 8'h00, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (irq !== 1'b0) begin errors++; $display("FAIL timer_early%0d: irq got %b want 0", i, irq); end
      end
      @(negedge clk);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL timer_rise: irq got %b want 1", irq); end
      bus_read(8'hFD, 1'b1, d);
      checks++;
      if (d !== 8'h81) begin errors++; $display("FAIL timer_status: got %h want 81", d); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL timer_fall: irq got %b want 0", irq); end
      bus_read(8'hFE, 1'b1, d);
      checks++;
      if (d !== 8'h03) begin errors++; $display("FAIL timer_cmp: got %h want 03", d); end
      // Counter sequence after the match: 0 (edge 7), 1, 2 at this read's edge.
      bus_read(8'hFF, 1'b1, d);
      checks++;
      if (d !== 8'h02) begin errors++; $display("FAIL timer_cnt: got %h want 02", d); end
   endtask
`else
   task automatic test_timer_absent();
      logic [7:0] d;
      do_reset();
      bus_write(8'hFE, 8'h55, 1'b1);
      bus_write(8'hFF, 8'h10, 1'b1);
      bus_read(8'hFE, 1'b1, d);
      checks++;
      if (d !== 8'h00) begin errors++; $display("FAIL notimer_cmp: got %h want 00", d); end
      bus_read(8'hFF, 1'b1, d);
      checks++;
      if (d !== 8'h00) begin errors++; $display("FAIL notimer_cnt: got %h want 00", d); end
      for (int i = 0; i < 300; i++) @(negedge clk);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL notimer_irq: got %b want 0", irq); end
      bus_read(8'hFD, 1'b1, d);
      checks++;
      if (d !== 8'h01) begin errors++; $display("FAIL notimer_status: got %h want 01", d); end
   endtask
`endif

   task automatic test_unselected_reset();
      logic [7:0] d;
      do_reset();
      bus_write(8'hFC, 8'h5A, 1'b1);
      bus_read(8'hFC, 1'b1, d);
      bus_write(8'hFC, 8'h77, 1'b0);
      bus_write(8'hF8, 8'h78, 1'b1);
      bus_read(8'hFD, 1'b0, d);
      checks++;
      if (d !== 8'h5A) begin errors++; $display("FAIL unsel_rdata: got %h want 5a", d); end
      bus_read(8'hF9, 1'b1, d);
      checks++;
      if (d !== 8'h5A) begin errors++; $display("FAIL unsel_window: got %h want 5a", d); end
      bus_read(8'hFD, 1'b1, d);
      checks++;
      if (d !== 8'h04) begin errors++; $display("FAIL unsel_status: got %h want 04", d); end
      bus_write(8'hFC, 8'h5B, 1'b1);
      bus_write(8'hFC, 8'h5C, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (tx_valid !== 1'b0 || tx_data !== 8'h00 || rdata !== 8'h00) begin
         errors++; $display("FAIL async_reset: valid=%b data=%h rdata=%h want 0/00/00", tx_valid, tx_data, rdata);
      end
      @(negedge clk);
      reset = 1'b0;
      bus_read(8'hFD, 1'b1, d);
      checks++;
      if (d !== 8'h01) begin errors++; $display("FAIL post_reset_status: got %h want 01", d); end
   endtask

   // Nine pushes through a depth-4 FIFO so both pointers wrap twice.
   task automatic test_back_to_back();
      logic [7:0] d;
      do_reset();
      exp_q.delete();
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 3; i++) push_byte(8'(8'hB0 + 8'(r * 16 + i)));
         bus_read(8'hFC, 1'b1, d);
         checks++;
         if (d !== exp_q[0]) begin errors++; $display("FAIL b2b_peek%0d: got %h want %h", r, d, exp_q[0]); end
         tx_ready = 1'b1;
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin
               errors++; $display("FAIL b2b_drain%0d_%0d: valid=%b data=%h want 1/%h", r, i, tx_valid, tx_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
            @(negedge clk);
         end
         tx_ready = 1'b0;
         checks++;
         if (tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty%0d: tx_valid got %b want 0", r, tx_valid); end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset    = 1'b1;
      read     = 1'b0;
      write    = 1'b0;
      addr     = 8'h00;
      wdata    = 8'h00;
      ramsel   = 1'b0;
      tx_ready = 1'b0;
      test_reset();
      test_push_status();
      test_overflow();
      test_full_push_pop();
      test_underflow();
`ifdef TINY_MMIO_TIMER_EN
      test_timer();
`else
      test_timer_absent();
`endif
      test_unselected_reset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tiny_mmio_resp.md
TINY_MMIO_RESP -- requirements
Module: tiny_mmio_resp

Interface
REQ-001 The block SHALL have parameter BASE, default 8'hFC, meaning the data-space base address of a 4-byte register window (BASE[1:0] = 0).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the TX FIFO depth; the only legal values are 2 and 4.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have ports read and write, input, 1 bit each: core bus strobes.
REQ-006 The block SHALL have ports addr and wdata, input, 8 bits each: core bus address and write data.
REQ-007 The block SHALL have port ramsel, input, 1 bit: 1 selects data space.
REQ-008 The block SHALL have port rdata, output, 8 bits: registered read data.
REQ-009 The block SHALL have ports tx_data (output, 8 bits), tx_valid (output, 1 bit) and tx_ready (input, 1 bit): the FIFO drain handshake.
REQ-010 The block SHALL have port irq, output, 1 bit: the timer flag level.

Function
REQ-011 Select SHALL be true iff ramsel=1 and addr[7:2]=BASE[7:2]; offset = addr[1:0].
REQ-012 A selected write SHALL take effect on the clk edge where write=1; a selected read SHALL load rdata on the clk edge where read=1, i.e. data is valid the cycle after the strobe; rdata SHALL hold otherwise.
REQ-013 Offset 0 (DATA): a write pushes wdata; a read returns the FIFO head without popping, or 8'h00 when empty.
REQ-014 Offset 1 (STATUS): the read value SHALL be {timer_flag, underflow, overflow, count[2:0], full, empty}.
REQ-015 A STATUS read SHALL clear bits 7:5 after sampling; a set event in the same cycle SHALL win over the clear.
REQ-016 Offset 2 (CMP): read/write 8-bit compare register.
REQ-017 Offset 3 (CNT): a read returns the counter value; a write loads the counter with wdata.
REQ-018 tx_valid SHALL equal !empty and tx_data SHALL equal the head; a pop SHALL occur on an edge with tx_valid && tx_ready.
REQ-019 A push when full without a simultaneous pop SHALL be dropped and set overflow.
REQ-020 A push when full with a simultaneous pop SHALL be accepted; count is unchanged and overflow stays clear.
REQ-021 A push when empty SHALL appear on tx_valid the next cycle; no same-cycle bypass.
REQ-022 A DATA read when empty SHALL set underflow.
REQ-023 FIFO pointers SHALL wrap modulo DEPTH.
REQ-024 The counter SHALL increment by 1 every cycle, wrapping 8'hFF to 8'h00.
REQ-025 When counter==CMP, the next counter value SHALL be 0 and timer_flag SHALL set.
REQ-026 A CNT write SHALL override both the increment and the match reload in that cycle.
REQ-027 irq SHALL equal timer_flag.
REQ-028 An unselected bus access SHALL change no state and leave rdata unchanged.

Reset
REQ-029 While reset=1, asynchronously: rdata=0, FIFO empty (tx_valid=0, tx_data=0), count=0, sticky bits=0, CMP=8'hFF, counter=0, irq=0.
REQ-030 Reset asserted mid-operation SHALL discard FIFO contents; the first edge after release behaves as a fresh start.

Configuration
REQ-031 With macro TINY_MMIO_TIMER_EN defined, the timer SHALL be present (offsets 2, 3, STATUS bit7, irq).
REQ-032 Without TINY_MMIO_TIMER_EN, offsets 2 and 3 SHALL read 8'h00 with writes ignored, STATUS bit7 SHALL be 0, irq SHALL be 0, and no counter/CMP flops SHALL exist.

Verification
REQ-033 Reset release; push 8'h11, 8'h22 at 0xFC with tx_ready=0 -> STATUS=8'h08; tx_data=8'h11, tx_valid=1.
REQ-034 Push 5 bytes with DEPTH=4 and tx_ready=0 -> STATUS=8'h32, then STATUS=8'h12 on the following read; the fifth byte is lost.
REQ-035 FIFO full, push 8'h55 in the same cycle as tx_ready=1 -> count stays 4, overflow=0, 8'h55 emerges fourth.
REQ-036 Empty FIFO, read 0xFC -> rdata=8'h00, STATUS bit6=1.
REQ-037 TIMER_EN defined; write CMP=8'h03, CNT=8'h00 -> irq rises 4 cycles later; STATUS read returns bit7=1 and irq falls.
REQ-038 Access at 0xFC with ramsel=0, and reset asserted with 3 entries queued -> no state change; tx_valid=0 immediately.
